pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//   Program-counter register and instruction-fetch sequencer for the MIPS core.
//   Holds the architectural PC and generates the sequential successor (PC+4).
//   Selects the next PC from exception, eret, jump and branch redirects.
//   Drives a req/ready instruction-memory handshake and presents one fetched word
//   at a time to decode, with a stall hold.
// PARAMETERS
//   RESET_PC    32'h0040_0000  PC loaded on reset
//   EXC_VECTOR  32'h0040_0004  exception entry address
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   rst         in   1   synchronous, active-high reset
//   stall       in   1   decode cannot accept the presented instruction this cycle
//   br_take     in   1   branch taken (valid only in a consume cycle)
//   br_target   in   32  branch target
//   jmp_take    in   1   j/jal/jr/jalr taken (valid only in a consume cycle)
//   jmp_target  in   32  jump target
//   eret_take   in   1   eret executed (valid only in a consume cycle)
//   epc         in   32  return address from CP0
//   exc_take    in   1   exception/interrupt request; sampled in every state
//   imem_req    out  1   fetch request
//   imem_addr   out  32  fetch address; word aligned, [1:0] always 2'b00
//   imem_ready  in   1   memory returns imem_rdata this cycle
//   imem_rdata  in   32  fetched word
//   inst_valid  out  1   inst/pc hold a fetched instruction
//   inst        out  32  fetched instruction
//   pc          out  32  address of inst
//   pc_plus4    out  32  pc + 4, modulo 2^32; combinational from pc
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=S_RST, imem_req=0, inst_valid=0, inst=0, pend_valid=0.
//   States:
//     S_RST:   imem_req=0; unconditionally -> S_REQ next cycle.
//     S_REQ:   imem_req=1, imem_addr=pc; address held stable until imem_ready.
//     S_VALID: inst_valid=1; inst and pc held.
//   Consume cycle: state==S_VALID && !stall.
//   Redirect priority: exc_take > eret_take > jmp_take > br_take > sequential (pc+4).
//   Target selection:
//     exc_take -> EXC_VECTOR
//     eret -> epc
//     jump -> jmp_target
//     branch -> br_target
//     Bits [1:0] of every target are forced to 0.
//   eret/jmp/br are ignored outside consume cycles.
//   S_REQ, imem_ready=0:
//     exc_take=1 sets pend_valid=1, pend_pc=EXC_VECTOR; stays S_REQ.
//   S_REQ, imem_ready=1:
//     - exc_take=1 this cycle: discard word; pc<=EXC_VECTOR; clear pend; stay S_REQ.
//     - else if pend_valid: discard word; pc<=pend_pc; clear pend; stay S_REQ.
//     - else: inst<=imem_rdata; inst_valid<=1; -> S_VALID.
//   S_VALID, stall=1, exc_take=0: hold everything, no request.
//   S_VALID, exc_take=1 (stall ignored): inst_valid<=0; pc<=EXC_VECTOR; -> S_REQ.
//   Consume cycle without exc:
//     pc<=selected target (or pc+4); inst_valid<=0; -> S_REQ.
//   Latency: a request with ready in its first S_REQ cycle gives inst_valid the
//     next cycle. Peak throughput is 1 instruction per 2 cycles.
//   Wrap: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; no flag.
//   rst mid-request overrides all other inputs; the returned word is dropped
//     and imem_req deasserts the next cycle.
//   stall is ignored outside S_VALID.
// TESTING
//   1. rst 2 cycles, release; ready tied 1; rdata=addr -> req at 0x00400000;
//      inst_valid in cycle 3 with pc=0x00400000, inst=0x00400000; next addr 0x00400004.
//   2. ready low 3 cycles in S_REQ -> imem_addr stable 0x00400004; req stays 1;
//      inst_valid rises the cycle after ready.
//   3. stall=1 for 4 cycles in S_VALID -> inst, pc unchanged; imem_req=0;
//      release -> next req at pc+4.
//   4. consume with br_take=1, br_target=0x00400103, and jmp_take=1 in the same
//      cycle -> next imem_addr=jmp_target&~3; with br only -> 0x00400100.
//   5. exc_take pulse while S_REQ waiting, ready 2 cycles later -> returned word
//      dropped (inst_valid stays 0); next req at 0x00400004.
//   6. pc=0xFFFFFFFC consumed sequentially -> pc_plus4=0, next addr 0x00000000;
//      rst asserted during S_REQ -> req=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// The PC register feeds a req/ready instruction-memory handshake. The fetched
// word is held in front of decode until it is consumed. The next PC comes from
// the exception vector, eret, a jump, a branch or PC+4, in that order of priority.
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        jmp_take,
    input  logic [31:0] jmp_target,
    input  logic        eret_take,
    input  logic [31:0] epc,
    input  logic        exc_take,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // The exception vector gets the same alignment as every other target.
    localparam logic [31:0] EXC_PC = {EXC_VECTOR[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] seq_pc;
    logic [31:0] redir_pc;
    logic        consume;

    assign seq_pc  = pc_q + 32'd4;
    assign consume = (state_q == S_VALID) && !stall;

    // Redirect target for a consume cycle without exception: eret > jump > branch > pc+4.
    always_comb begin
        redir_pc = seq_pc;
        if (eret_take) begin
            redir_pc = epc;
        end else if (jmp_take) begin
            redir_pc = jmp_target;
        end else if (br_take) begin
            redir_pc = br_target;
        end
        redir_pc[1:0] = 2'b00;
    end

    // State register; reset overrides every other input, including a returning word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a word is only accepted when no exception is pending or arriving.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_REQ;
            S_REQ:   if (imem_ready && !exc_take && !pend_valid_q) state_d = S_VALID;
            S_VALID: if (exc_take || !stall) state_d = S_REQ;
            default: state_d = S_RST;
        endcase
    end

    // Output decode: request while fetching, valid while holding a word.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            S_REQ:   imem_req   = 1'b1;
            S_VALID: inst_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values. An exception seen while a fetch is outstanding is
    // remembered, so the word that eventually returns is discarded.
    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        case (state_q)
            S_REQ: begin
                if (!imem_ready) begin
                    if (exc_take) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = EXC_PC;
                    end
                end else if (exc_take) begin
                    pc_d         = EXC_PC;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    pc_d         = pend_pc_q;
                    pend_valid_d = 1'b0;
                end else begin
                    inst_d = imem_rdata;
                end
            end
            S_VALID: begin
                if (exc_take) begin
                    pc_d = EXC_PC;
                end else if (consume) begin
                    pc_d = redir_pc;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign imem_addr = {pc_q[31:2], 2'b00};
    assign inst      = inst_q;
    assign pc        = pc_q;
    assign pc_plus4  = seq_pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios followed by random traffic.
// The driver keeps a transaction-level model: the address of the next
// instruction that must reach decode. It pushes that into a queue, and a
// separate monitor pops one entry each time a new instruction appears.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst, stall, br_take, jmp_take, eret_take, exc_take, imem_ready;
    logic [31:0] br_target, jmp_target, epc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_deliv  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] cur_pc;
    logic        prev_valid = 1'b0;
    logic        have_cur   = 1'b0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_take    (br_take),
        .br_target  (br_target),
        .jmp_take   (jmp_take),
        .jmp_target (jmp_target),
        .eret_take  (eret_take),
        .epc        (epc),
        .exc_take   (exc_take),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    // Memory contents: a scramble of the address so inst and pc never coincide.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_q.delete();
        exp_q.push_back(a);
        model_pc = a;
    endtask

    // Apply the current inputs for one cycle and advance the model accordingly.
    task automatic go();
        logic [31:0] nxt;
        imem_rdata = memf(imem_addr);
        if (rst) begin
            expect_fetch(RESET_PC);
        end else if (exc_take && (imem_req || inst_valid)) begin
            expect_fetch(EXC_VECTOR);
        end else if (inst_valid && !stall) begin
            if (eret_take)     nxt = epc;
            else if (jmp_take) nxt = jmp_target;
            else if (br_take)  nxt = br_target;
            else               nxt = model_pc + 32'd4;
            expect_fetch(nxt & ~32'd3);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        rst = 1'b0; stall = 1'b0; br_take = 1'b0; jmp_take = 1'b0;
        eret_take = 1'b0; exc_take = 1'b0; imem_ready = 1'b1;
        br_target = 32'd0; jmp_target = 32'd0; epc = 32'd0;
    endtask

    // Monitor: one line per delivered instruction; checks hold and invariants each cycle.
    always @(negedge clk) begin
        chk("pc_plus4", pc_plus4, pc + 32'd4);
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        chk("req_valid_excl", {31'd0, imem_req && inst_valid}, 32'd0);
        if (inst_valid && !prev_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                have_cur = 1'b0;
                $display("FAIL unexpected_inst: got pc %08h expected no instruction", pc);
            end else begin
                cur_pc   = exp_q.pop_front();
                have_cur = 1'b1;
                n_deliv++;
                $display("inst #%0d pc=%08h inst=%08h", n_deliv, pc, inst);
            end
        end
        if (inst_valid && have_cur) begin
            chk("inst_pc", pc, cur_pc);
            chk("inst_word", inst, memf(cur_pc));
        end
        prev_valid = inst_valid;
    end

    initial begin
        clear_in();
        rst        = 1'b1;
        imem_rdata = 32'd0;
        model_pc   = RESET_PC;
        @(negedge clk);
        #1;
        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        go();
        rst = 1'b0;
        go();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        go();
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        go();
        chk("seq_addr", imem_addr, 32'h0040_0004);

        // Memory not ready for three cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h0040_0004);
            chk("wait_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        go();
        chk("late_valid", {31'd0, inst_valid}, 32'd1);

        // Stall hold
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go();
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        stall = 1'b0;
        go();
        chk("post_stall_addr", imem_addr, 32'h0040_0008);

        // Jump beats branch; then branch alone
        go();
        br_take = 1'b1; br_target = 32'h0040_0103;
        jmp_take = 1'b1; jmp_target = 32'h0040_0207;
        go();
        chk("jmp_over_br", imem_addr, 32'h0040_0204);
        clear_in();
        go();
        br_take = 1'b1; br_target = 32'h0040_0103;
        go();
        chk("br_addr", imem_addr, 32'h0040_0100);
        clear_in();

        // Exception while a fetch is outstanding drops the returning word
        imem_ready = 1'b0; exc_take = 1'b1;
        go();
        exc_take = 1'b0;
        go();
        imem_ready = 1'b1;
        go();
        chk("exc_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("exc_req", {31'd0, imem_req}, 32'd1);
        chk("exc_addr", imem_addr, EXC_VECTOR);
        go();

        // Wrap at the top of the address space
        br_take = 1'b1; br_target = 32'hFFFF_FFFE;
        go();
        clear_in();
        go();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'd0);
        go();
        chk("wrap_addr", imem_addr, 32'd0);

        // Reset during a request
        rst = 1'b1;
        go();
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, RESET_PC);
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b0;
        go();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            stall      = ($urandom_range(0, 9) < 3);
            imem_ready = ($urandom_range(0, 9) < 6);
            exc_take   = (imem_req || inst_valid) && ($urandom_range(0, 19) == 0);
            eret_take  = ($urandom_range(0, 7) == 0);
            jmp_take   = ($urandom_range(0, 3) == 0);
            br_take    = ($urandom_range(0, 3) == 0);
            epc        = $urandom;
            jmp_target = $urandom;
            br_target  = $urandom;
            go();
        end
        clear_in();

        n_checks++;
        if (n_deliv < 200) begin
            n_fail++;
            $display("FAIL liveness: got %0d instructions expected at least 200", n_deliv);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
